pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the pipelined RISC-V core, and successor to the single-register PC. It holds the fetch address and advances it sequentially. It accepts ID-stage jump/return predictions through a small return-address stack (RAS) and EX-stage redirects. A redirect that arrives during a hazard stall or a cache/memory stall is captured, not lost.

## Interface
Parameters:
- XLEN, 32, PC and address width
- RESET_VEC, 0, PC value after reset and while not started
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  run enable; low forces idle
- stall_i  in  1  hazard-unit stall
- mem_stall_i  in  1  cache/memory stall
- pc_write_i  in  1  PC write enable from hazard unit
- redirect_valid_i  in  1  EX-resolved mispredict/jalr
- redirect_pc_i  in  XLEN  corrected target
- jump_valid_i  in  1  ID-stage direct jump (jal/taken prediction)
- jump_pc_i  in  XLEN  ID-stage target
- call_i  in  1  push link address (jal/jalr with rd=x1/x5)
- link_pc_i  in  XLEN  address pushed on call
- ret_i  in  1  predicted return; next PC = RAS top
- pc_o  out  XLEN  current fetch PC (registered)
- running_o  out  1  state is RUN
- pending_o  out  1  captured redirect awaiting application
- ras_empty_o  out  1  RAS count = 0
- ras_full_o  out  1  RAS count = RAS_DEPTH

## Operation
- FSM with two states, IDLE and RUN.
  - Reset → IDLE.
  - IDLE → RUN when start_i=1.
  - RUN → IDLE when start_i=0; on that transition pc_o←RESET_VEC, RAS cleared, pending cleared.
- adv = RUN & ~stall_i & ~mem_stall_i & pc_write_i.
- Next-PC priority when adv=1:
  1. redirect_valid_i → redirect_pc_i
  2. pending → pending_pc
  3. ret_i → RAS top, or pc_o+INC if the RAS is empty
  4. jump_valid_i → jump_pc_i
  5. otherwise pc_o+INC
- Bit 0 of every loaded target is forced to 0.
- pc_o+INC wraps modulo 2^XLEN.
- Redirect while ~adv in RUN: pending←1, pending_pc←redirect_pc_i. A later redirect overwrites it, so the newest wins.
- pending clears on the first adv cycle. It also clears if a live redirect is taken in that same cycle.
- RAS is a circular buffer of RAS_DEPTH entries with a top pointer and a count that saturates at RAS_DEPTH. It updates only on adv cycles, and only when neither redirect nor pending takes priority.
  - push (call_i): write link_pc_i at top+1. When full, the oldest entry is overwritten and count stays RAS_DEPTH.
  - pop (ret_i): top−1 and count−1. A pop on empty is a no-op.
  - call_i & ret_i together: replace the top entry in place; count unchanged (or 1 if it was empty).
- Redirects do not repair the RAS. A misprediction only costs performance, never correctness.

## Timing
- Reset values: pc_o=RESET_VEC, running_o=0, pending_o=0, ras_empty_o=1, ras_full_o=0. RAS pointer and count are 0.
- Reset has priority over every other input on the same edge.
- pc_o updates one edge after adv with its selected source. It is unchanged on every ~adv cycle.
- A captured redirect appears on pc_o on the edge that ends the first adv cycle.
- start_i rising edge: running_o=1 after that edge. pc_o first advances on the following adv edge.
- Status flags are registered and reflect the RAS state after each edge.

## Structure
- The shared core package holds:
  - the FSM state typedef (PC_IDLE, PC_RUN)
  - the next-PC source encoding (SRC_REDIR, SRC_PEND, SRC_RAS, SRC_JUMP, SRC_SEQ)
  - the default RESET_VEC and INC constants
- One sub-module, pc_ras, contains the circular stack, pointer, count and flags. It takes push, pop, push_data and outputs top.
- The next-PC mux and FSM live in pc_unit.

## Test plan
- Reset and start: rst_i=0 for 2 cycles, then start_i=1 with no stalls → pc_o goes 0, 0, 4, 8, 12 on successive edges.
- Stall capture: at pc_o=0x10, mem_stall_i=1 for 3 cycles, redirect 0x80 during the 2nd stall cycle → pending_o=1, pc_o holds 0x10; after the stall clears, pc_o=0x80 and pending_o=0.
- Priority: redirect 0x200, jump 0x300 and ret_i all in the same adv cycle → pc_o=0x200 and the RAS is unchanged.
- RAS overflow (RAS_DEPTH=4): push 0x100, 0x104, 0x108, 0x10C, 0x110, then 5 rets → targets 0x110, 0x10C, 0x108, 0x104, then a fallback of pc+4 with ras_empty_o=1.
- Simultaneous call and ret with top=0x40 and link 0x50 → pc_o=0x40 and the new top is 0x50 with count unchanged.
- Mid-run stop and reset: start_i=0 at pc 0x24 → running_o=0, pc_o=0, RAS empty. Reassert start_i, then assert rst_i=0 during a pending redirect → all outputs return to reset values.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared types and defaults for the program-counter unit
// Contents: FSM state type, next-PC source encoding, default reset vector and increment.
package pc_unit_pkg;

    typedef enum logic {
        PC_IDLE,
        PC_RUN
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_REDIR,
        SRC_PEND,
        SRC_RAS,
        SRC_JUMP,
        SRC_SEQ
    } pc_src_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_INC       = 32'd4;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count
// Ports: clk_i, rst_i (sync active-low), clear_i, push_i, pop_i, push_data_i,
//        top_o (entry at top pointer), empty_o, full_o.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [CW-1:0]   cnt_q;

    assign ptr_inc = ptr_q + 1'b1;
    assign ptr_dec = ptr_q - 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i && pop_i) begin
            // Replace-in-place keeps the pointer; an empty stack gains its first entry.
            if (cnt_q == '0) begin
                cnt_q <= CW'(1);
            end
        end else if (push_i) begin
            // When full the pointer still advances and silently drops the oldest entry.
            ptr_q <= ptr_inc;
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entries carry no reset; an empty stack is never consulted for a target.
    always_ff @(posedge clk_i) begin
        if (rst_i && !clear_i) begin
            if (push_i && pop_i) begin
                mem_q[ptr_q] <= push_data_i;
            end else if (push_i) begin
                mem_q[ptr_inc] <= push_data_i;
            end
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with RAS prediction and stall-safe redirects
// Ports: clk_i, rst_i (sync active-low), start_i, stall_i, mem_stall_i, pc_write_i,
//        redirect_valid_i/redirect_pc_i, jump_valid_i/jump_pc_i, call_i, link_pc_i, ret_i,
//        pc_o, running_o, pending_o, ras_empty_o, ras_full_o.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] INC       = XLEN'(DEFAULT_INC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            mem_stall_i,
    input  logic            pc_write_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            jump_valid_i,
    input  logic [XLEN-1:0] jump_pc_i,
    input  logic            call_i,
    input  logic [XLEN-1:0] link_pc_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            running_o,
    output logic            pending_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);
    pc_state_t       state_q, state_d;
    pc_src_t         src;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pending_pc_q;
    logic            pending_q;
    logic            adv;
    logic            stop;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    function automatic logic [XLEN-1:0] even(input logic [XLEN-1:0] a);
        return {a[XLEN-1:1], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        stop    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            PC_IDLE: if (start_i) state_d = PC_RUN;
            PC_RUN: begin
                if (!start_i) begin
                    state_d = PC_IDLE;
                    stop    = 1'b1;
                end else begin
                    adv = ~stall_i & ~mem_stall_i & pc_write_i;
                end
            end
            default: state_d = PC_IDLE;
        endcase
    end

    always_comb begin
        src = SRC_SEQ;
        if (redirect_valid_i)         src = SRC_REDIR;
        else if (pending_q)           src = SRC_PEND;
        else if (ret_i && !ras_empty) src = SRC_RAS;
        else if (ret_i)               src = SRC_SEQ;
        else if (jump_valid_i)        src = SRC_JUMP;

        next_pc = pc_q + INC;
        unique case (src)
            SRC_REDIR: next_pc = even(redirect_pc_i);
            SRC_PEND:  next_pc = even(pending_pc_q);
            SRC_RAS:   next_pc = even(ras_top);
            SRC_JUMP:  next_pc = even(jump_pc_i);
            default:   next_pc = pc_q + INC;
        endcase
    end

    // Any redirect, live or captured, pre-empts the stack so speculative calls/rets are ignored.
    assign ras_push = adv & ~redirect_valid_i & ~pending_q & call_i;
    assign ras_pop  = adv & ~redirect_valid_i & ~pending_q & ret_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= PC_IDLE;
            pc_q         <= RESET_VEC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (stop) begin
                pc_q      <= RESET_VEC;
                pending_q <= 1'b0;
            end else if (adv) begin
                pc_q      <= next_pc;
                pending_q <= 1'b0;
            end else if ((state_q == PC_RUN) && redirect_valid_i) begin
                pending_q    <= 1'b1;
                pending_pc_q <= redirect_pc_i;
            end
        end
    end

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (stop),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (link_pc_i),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign pc_o        = pc_q;
    assign running_o   = (state_q == PC_RUN);
    assign pending_o   = pending_q;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit
module tb_pc_unit;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, stall_i, mem_stall_i, pc_write_i;
    logic        redirect_valid_i, jump_valid_i, call_i, ret_i;
    logic [31:0] redirect_pc_i, jump_pc_i, link_pc_i;
    logic [31:0] pc_o;
    logic        running_o, pending_o, ras_empty_o, ras_full_o;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference state: stack kept as a queue, newest entry at the back.
    bit          m_run, m_pend;
    logic [31:0] m_pc, m_ppc;
    logic [31:0] m_ras[$];
    bit          x_run, x_pend;
    logic [31:0] x_pc, x_ppc;
    logic [31:0] x_ras[$];

    pc_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .stall_i          (stall_i),
        .mem_stall_i      (mem_stall_i),
        .pc_write_i       (pc_write_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .jump_valid_i     (jump_valid_i),
        .jump_pc_i        (jump_pc_i),
        .call_i           (call_i),
        .link_pc_i        (link_pc_i),
        .ret_i            (ret_i),
        .pc_o             (pc_o),
        .running_o        (running_o),
        .pending_o        (pending_o),
        .ras_empty_o      (ras_empty_o),
        .ras_full_o       (ras_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Next-state rules written straight from the behaviour description.
    task automatic model_calc();
        bit adv;
        x_run = m_run; x_pend = m_pend; x_pc = m_pc; x_ppc = m_ppc; x_ras = m_ras;
        if (!rst_i) begin
            x_run = 0; x_pend = 0; x_pc = 0; x_ras.delete();
        end else if (!m_run) begin
            if (start_i) x_run = 1;
        end else if (!start_i) begin
            x_run = 0; x_pend = 0; x_pc = 0; x_ras.delete();
        end else begin
            adv = !stall_i && !mem_stall_i && pc_write_i;
            if (adv) begin
                if (redirect_valid_i)  x_pc = redirect_pc_i & ~32'd1;
                else if (m_pend)       x_pc = m_ppc & ~32'd1;
                else begin
                    if (ret_i) x_pc = (m_ras.size() > 0) ? (m_ras[$] & ~32'd1) : m_pc + 32'd4;
                    else if (jump_valid_i) x_pc = jump_pc_i & ~32'd1;
                    else x_pc = m_pc + 32'd4;
                    if (call_i && ret_i) begin
                        if (x_ras.size() == 0) x_ras.push_back(link_pc_i);
                        else x_ras[x_ras.size()-1] = link_pc_i;
                    end else if (call_i) begin
                        x_ras.push_back(link_pc_i);
                        if (x_ras.size() > 4) void'(x_ras.pop_front());
                    end else if (ret_i && x_ras.size() > 0) begin
                        void'(x_ras.pop_back());
                    end
                end
                x_pend = 0;
            end else if (redirect_valid_i) begin
                x_pend = 1; x_ppc = redirect_pc_i;
            end
        end
    endtask

    task automatic tick();
        model_calc();
        @(posedge clk_i);
        #1;
        m_run = x_run; m_pend = x_pend; m_pc = x_pc; m_ppc = x_ppc; m_ras = x_ras;
    endtask

    task automatic idle_in();
        stall_i = 0; mem_stall_i = 0; pc_write_i = 1;
        redirect_valid_i = 0; jump_valid_i = 0; call_i = 0; ret_i = 0;
        redirect_pc_i = 0; jump_pc_i = 0; link_pc_i = 0;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("pc_o", pc_o, m_pc);
            check("running_o", {31'd0, running_o}, {31'd0, m_run});
            check("pending_o", {31'd0, pending_o}, {31'd0, m_pend});
            check("ras_empty_o", {31'd0, ras_empty_o}, {31'd0, m_ras.size() == 0});
            check("ras_full_o", {31'd0, ras_full_o}, {31'd0, m_ras.size() == 4});
        end
    end

    initial begin
        idle_in();
        rst_i = 0; start_i = 0;
        tick(); chk_en = 1; tick();
        check("rst pc", pc_o, 32'h0);
        check("rst running", {31'd0, running_o}, 32'd0);
        check("rst empty", {31'd0, ras_empty_o}, 32'd1);

        rst_i = 1; start_i = 1;
        tick(); check("start pc", pc_o, 32'h0);
        check("start running", {31'd0, running_o}, 32'd1);
        tick(); tick(); tick(); check("seq pc", pc_o, 32'hC);
        tick(); check("pc 0x10", pc_o, 32'h10);

        mem_stall_i = 1; tick();
        redirect_valid_i = 1; redirect_pc_i = 32'h80; tick();
        redirect_valid_i = 0; tick();
        check("stall pending", {31'd0, pending_o}, 32'd1);
        check("stall hold", pc_o, 32'h10);
        mem_stall_i = 0; tick();
        check("pending applied", pc_o, 32'h80);
        check("pending cleared", {31'd0, pending_o}, 32'd0);

        call_i = 1;
        for (int i = 0; i < 5; i++) begin
            link_pc_i = 32'h100 + 32'(4 * i);
            tick();
        end
        call_i = 0;
        check("ras full", {31'd0, ras_full_o}, 32'd1);

        redirect_valid_i = 1; redirect_pc_i = 32'h200;
        jump_valid_i = 1; jump_pc_i = 32'h300; ret_i = 1;
        tick();
        redirect_valid_i = 0; jump_valid_i = 0;
        check("priority pc", pc_o, 32'h200);
        check("priority ras kept", {31'd0, ras_full_o}, 32'd1);

        tick(); check("ret1", pc_o, 32'h110);
        tick(); check("ret2", pc_o, 32'h10C);
        tick(); check("ret3", pc_o, 32'h108);
        tick(); check("ret4", pc_o, 32'h104);
        tick(); check("ret empty fallback", pc_o, 32'h108);
        check("ret empty flag", {31'd0, ras_empty_o}, 32'd1);
        ret_i = 0;

        call_i = 1; link_pc_i = 32'h40; tick();
        ret_i = 1; link_pc_i = 32'h50; tick();
        check("call+ret pc", pc_o, 32'h40);
        call_i = 0; tick();
        check("replaced top", pc_o, 32'h50);
        check("count unchanged", {31'd0, ras_empty_o}, 32'd1);
        ret_i = 0;

        redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC; tick();
        redirect_valid_i = 0; tick();
        check("wrap", pc_o, 32'h0);

        call_i = 1; link_pc_i = 32'h60; jump_valid_i = 1; jump_pc_i = 32'h25; tick();
        call_i = 0; jump_valid_i = 0;
        check("jump bit0 cleared", pc_o, 32'h24);

        start_i = 0; tick();
        check("stop pc", pc_o, 32'h0);
        check("stop running", {31'd0, running_o}, 32'd0);
        check("stop ras", {31'd0, ras_empty_o}, 32'd1);

        start_i = 1; tick();
        pc_write_i = 0; redirect_valid_i = 1; redirect_pc_i = 32'h90; tick();
        check("hold pending", {31'd0, pending_o}, 32'd1);
        rst_i = 0; tick();
        check("reset pc", pc_o, 32'h0);
        check("reset pending", {31'd0, pending_o}, 32'd0);
        check("reset running", {31'd0, running_o}, 32'd0);
        rst_i = 1; start_i = 0; idle_in(); tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
